// File: rtl/rule_unpacker.sv
// Rule unpacker: buffers one multi-lane beat of rule IDs and emits the
// non-null lanes one word at a time, with a terminator for empty final beats.
module rule_unpacker #(
    parameter int LANES      = 8,
    parameter int LANE_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LANES*LANE_WIDTH-1:0] in_usr_data,
    input  logic                        in_usr_valid,
    input  logic                        in_usr_sop,
    input  logic                        in_usr_eop,
    input  logic [3:0]                  in_usr_empty,
    output logic                        in_usr_ready,
    output logic [LANE_WIDTH-1:0]       out_rule_data,
    output logic                        out_rule_valid,
    output logic                        out_rule_last,
    input  logic                        out_rule_ready,
    output logic [31:0]                 rule_cnt,
    output logic [31:0]                 pkt_cnt,
    output logic [31:0]                 null_cnt,
    output logic                        proto_err
);

    localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic                  run_r;
    logic                  buf_valid_r;
    logic                  buf_eop_r;
    logic                  in_pkt_r;
    logic                  proto_err_r;
    logic [LANES-1:0]      mask_r;
    logic [LANE_WIDTH-1:0] lane_r [LANES];
    logic [31:0]           rule_cnt_r;
    logic [31:0]           pkt_cnt_r;
    logic [31:0]           null_cnt_r;

    logic [SEL_W-1:0]      sel_s;
    logic [LANES-1:0]      sel_oh_s;
    logic                  found_s;
    logic [LANES-1:0]      load_mask_s;
    logic                  mask_any_s;
    logic                  mask_one_s;
    logic                  accept_s;
    logic                  xfer_s;
    logic                  unused_s;

    assign unused_s = ^in_usr_empty;

    // Lowest-index pending lane, as index and one-hot
    always_comb begin
        sel_s    = '0;
        sel_oh_s = '0;
        found_s  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (!found_s && mask_r[i]) begin
                sel_s       = SEL_W'(i);
                sel_oh_s[i] = 1'b1;
                found_s     = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Non-null lane mask of the incoming beat
    always_comb begin
        load_mask_s = '0;
        for (int i = 0; i < LANES; i++) begin
            load_mask_s[i] = (in_usr_data[i*LANE_WIDTH +: LANE_WIDTH] != '0);
        end
    end

    assign mask_any_s = |mask_r;
    assign mask_one_s = mask_any_s && ((mask_r & (mask_r - LANES'(1))) == '0);

    // All handshake outputs decode registered state only
    assign in_usr_ready   = run_r && !buf_valid_r;
    assign out_rule_valid = buf_valid_r && (mask_any_s || buf_eop_r);
    assign out_rule_data  = mask_any_s ? lane_r[sel_s] : '0;
    assign out_rule_last  = buf_valid_r && buf_eop_r && (mask_one_s || !mask_any_s);

    assign accept_s = in_usr_valid && in_usr_ready;
    assign xfer_s   = out_rule_valid && out_rule_ready;

    assign rule_cnt  = rule_cnt_r;
    assign pkt_cnt   = pkt_cnt_r;
    assign null_cnt  = null_cnt_r;
    assign proto_err = proto_err_r;

    // Run enable: held off until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Beat buffer: load on accept, retire lanes as they are transferred
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_r <= 1'b0;
            buf_eop_r   <= 1'b0;
            mask_r      <= '0;
            for (int i = 0; i < LANES; i++) begin
                lane_r[i] <= '0;
            end
        end else if (accept_s) begin
            buf_valid_r <= 1'b1;
            buf_eop_r   <= in_usr_eop;
            mask_r      <= load_mask_s;
            for (int i = 0; i < LANES; i++) begin
                lane_r[i] <= in_usr_data[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end else if (xfer_s) begin
            mask_r <= mask_r & ~sel_oh_s;
            if (!mask_any_s || mask_one_s) begin
                buf_valid_r <= 1'b0;
            end else begin
                buf_valid_r <= 1'b1;
            end
        end else if (buf_valid_r && !mask_any_s && !buf_eop_r) begin
            // Empty mid-packet beat produces nothing and is dropped
            buf_valid_r <= 1'b0;
        end else begin
            buf_valid_r <= buf_valid_r;
        end
    end

    // Packet framing tracker with sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pkt_r    <= 1'b0;
            proto_err_r <= 1'b0;
        end else if (accept_s) begin
            in_pkt_r <= !in_usr_eop;
            if (in_usr_sop == in_pkt_r) begin
                proto_err_r <= 1'b1;
            end else begin
                proto_err_r <= proto_err_r;
            end
        end else begin
            in_pkt_r    <= in_pkt_r;
            proto_err_r <= proto_err_r;
        end
    end

    // Transfer statistics, free-running modulo 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rule_cnt_r <= 32'd0;
            pkt_cnt_r  <= 32'd0;
            null_cnt_r <= 32'd0;
        end else begin
            if (xfer_s && (out_rule_data != '0)) begin
                rule_cnt_r <= rule_cnt_r + 32'd1;
            end else begin
                rule_cnt_r <= rule_cnt_r;
            end
            if (xfer_s && out_rule_last) begin
                pkt_cnt_r <= pkt_cnt_r + 32'd1;
            end else begin
                pkt_cnt_r <= pkt_cnt_r;
            end
            if (xfer_s && !mask_any_s) begin
                null_cnt_r <= null_cnt_r + 32'd1;
            end else begin
                null_cnt_r <= null_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_rule_unpacker.sv
// Directed bench for rule_unpacker: expected words are queued as beats are
// issued and a separate monitor pops and compares on every output transfer.
module tb_rule_unpacker;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_usr_data;
    logic         in_usr_valid;
    logic         in_usr_sop;
    logic         in_usr_eop;
    logic [3:0]   in_usr_empty;
    logic         in_usr_ready;
    logic [15:0]  out_rule_data;
    logic         out_rule_valid;
    logic         out_rule_last;
    logic         out_rule_ready;
    logic [31:0]  rule_cnt;
    logic [31:0]  pkt_cnt;
    logic [31:0]  null_cnt;
    logic         proto_err;

    int tests;
    int fails;
    logic [16:0] exp_q [$];

    rule_unpacker #(.LANES(8), .LANE_WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_usr_data   (in_usr_data),
        .in_usr_valid  (in_usr_valid),
        .in_usr_sop    (in_usr_sop),
        .in_usr_eop    (in_usr_eop),
        .in_usr_empty  (in_usr_empty),
        .in_usr_ready  (in_usr_ready),
        .out_rule_data (out_rule_data),
        .out_rule_valid(out_rule_valid),
        .out_rule_last (out_rule_last),
        .out_rule_ready(out_rule_ready),
        .rule_cnt      (rule_cnt),
        .pkt_cnt       (pkt_cnt),
        .null_cnt      (null_cnt),
        .proto_err     (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] lane(input logic [127:0] base, input int i, input logic [15:0] v);
        logic [127:0] r;
        r = base;
        r[i*16 +: 16] = v;
        return r;
    endfunction

    task automatic push(input logic [15:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    // Present a beat once ready is seen; returns 1 time unit after the accept edge
    task automatic send(input logic [127:0] d, input logic sop, input logic eop);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_usr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_usr_ready) begin
            chk("send_ready_timeout", 32'd0, 32'd1);
        end else begin
            in_usr_data  = d;
            in_usr_sop   = sop;
            in_usr_eop   = eop;
            in_usr_valid = 1'b1;
            @(posedge clk);
            #1;
            in_usr_valid = 1'b0;
            in_usr_data  = '0;
            in_usr_sop   = 1'b0;
            in_usr_eop   = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_rule_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", {31'd0, (exp_q.size() == 0 && !out_rule_valid)}, 32'd1);
    endtask

    task automatic chk_cnt(input string tag, input int r, input int p, input int z);
        chk({tag, "_rule_cnt"}, rule_cnt, r);
        chk({tag, "_pkt_cnt"}, pkt_cnt, p);
        chk({tag, "_null_cnt"}, null_cnt, z);
    endtask

    // Monitor: every output transfer must match the head of the queue
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_rule_valid && out_rule_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {15'd0, out_rule_last, out_rule_data}, 32'h1ffff);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    chk("word_data", {16'd0, out_rule_data}, {16'd0, e[15:0]});
                    chk("word_last", {31'd0, out_rule_last}, {31'd0, e[16]});
                    chk("ready_low_in_emit", {31'd0, in_usr_ready}, 32'd0);
                end
            end
        end
    end

    initial begin
        logic [127:0] d;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        in_usr_data = '0;
        in_usr_valid = 1'b0;
        in_usr_sop = 1'b0;
        in_usr_eop = 1'b0;
        in_usr_empty = 4'd0;
        out_rule_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, in_usr_ready}, 32'd0);
        chk("rst_valid", {31'd0, out_rule_valid}, 32'd0);
        chk("rst_last", {31'd0, out_rule_last}, 32'd0);
        chk("rst_data", {16'd0, out_rule_data}, 32'd0);
        chk("rst_err", {31'd0, proto_err}, 32'd0);
        chk_cnt("rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("ready_before_run", {31'd0, in_usr_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_run", {31'd0, in_usr_ready}, 32'd1);

        // Scenario 1: three sparse lanes, back-to-back words
        d = lane(lane(lane('0, 0, 16'h0005), 2, 16'h0012), 7, 16'h0100);
        push(16'h0005, 1'b0);
        push(16'h0012, 1'b0);
        push(16'h0100, 1'b1);
        send(d, 1'b1, 1'b1);
        chk("s1_latency_valid", {31'd0, out_rule_valid}, 32'd1);
        chk("s1_ready_low", {31'd0, in_usr_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("s1_three_cycles_q", exp_q.size(), 32'd0);
        chk("s1_valid_done", {31'd0, out_rule_valid}, 32'd0);
        chk("s1_ready_back", {31'd0, in_usr_ready}, 32'd1);
        chk_cnt("s1", 3, 1, 0);

        // Scenario 2: rule then empty eop beat -> terminator
        push(16'h0033, 1'b0);
        push(16'h0000, 1'b1);
        send(lane('0, 1, 16'h0033), 1'b1, 1'b0);
        send('0, 1'b0, 1'b1);
        drain();
        chk_cnt("s2", 4, 2, 1);

        // Scenario 3: backpressure holds the presented word
        out_rule_ready = 1'b0;
        push(16'h0a01, 1'b0);
        push(16'h0b02, 1'b1);
        send(lane(lane('0, 3, 16'h0a01), 5, 16'h0b02), 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("s3_hold_valid", {31'd0, out_rule_valid}, 32'd1);
            chk("s3_hold_data", {16'd0, out_rule_data}, 32'h0a01);
            chk("s3_hold_last", {31'd0, out_rule_last}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_rule_ready = 1'b1;
        drain();
        chk_cnt("s3", 6, 3, 1);

        // Scenario 4: empty mid-packet beat is silently dropped
        push(16'h0007, 1'b0);
        push(16'h0044, 1'b1);
        send(lane('0, 0, 16'h0007), 1'b1, 1'b0);
        send('0, 1'b0, 1'b0);
        chk("s4_empty_no_valid", {31'd0, out_rule_valid}, 32'd0);
        chk("s4_empty_ready_low", {31'd0, in_usr_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("s4_empty_ready_back", {31'd0, in_usr_ready}, 32'd1);
        send(lane('0, 4, 16'h0044), 1'b0, 1'b1);
        drain();
        chk_cnt("s4", 8, 4, 1);
        chk("s4_no_err", {31'd0, proto_err}, 32'd0);

        // Scenario 5: sop inside a packet flags an error but still unpacks
        push(16'h0101, 1'b0);
        push(16'h0202, 1'b0);
        push(16'h0606, 1'b1);
        send(lane('0, 0, 16'h0101), 1'b1, 1'b0);
        chk("s5_err_before", {31'd0, proto_err}, 32'd0);
        send(lane(lane('0, 1, 16'h0202), 6, 16'h0606), 1'b1, 1'b1);
        chk("s5_err_set", {31'd0, proto_err}, 32'd1);
        drain();
        chk("s5_err_sticky", {31'd0, proto_err}, 32'd1);
        chk_cnt("s5", 11, 5, 1);

        // Scenario 6: reset during the second of three words
        push(16'h0011, 1'b0);
        send(lane(lane(lane('0, 0, 16'h0011), 1, 16'h0022), 2, 16'h0033), 1'b1, 1'b1);
        @(posedge clk);
        #2;
        chk("s6_second_word_up", {16'd0, out_rule_data}, 32'h0022);
        rst_n = 1'b0;
        #1;
        chk("s6_async_valid", {31'd0, out_rule_valid}, 32'd0);
        chk("s6_async_ready", {31'd0, in_usr_ready}, 32'd0);
        chk("s6_async_err", {31'd0, proto_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_cnt("s6_rst", 0, 0, 0);
        chk("s6_q_empty", exp_q.size(), 32'd0);
        push(16'h0777, 1'b0);
        push(16'h0888, 1'b1);
        send(lane(lane('0, 0, 16'h0777), 7, 16'h0888), 1'b1, 1'b1);
        drain();
        chk_cnt("s6_post", 2, 1, 0);
        chk("s6_post_err", {31'd0, proto_err}, 32'd0);

        // Missing sop outside a packet also flags the error
        push(16'h0abc, 1'b1);
        send(lane('0, 2, 16'h0abc), 1'b0, 1'b1);
        chk("nosop_err", {31'd0, proto_err}, 32'd1);
        drain();
        chk_cnt("nosop", 3, 2, 0);

        repeat (3) @(posedge clk);
        chk("final_q_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
